vga_timing_pattern_gen: RTL and testbench



---
 rtl/vga_timing_pattern_gen.sv | 172 +++++++++++++++++
 tb/tb_vga_timing_pattern_gen.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA timing generator with a built-in test-pattern source.
// Produces registered hsync/vsync/data-enable, pixel coordinates, line and
// frame strobes, a frame counter and 12-bit RGB driven by one of four
// patterns: solid colour, eight colour bars, checkerboard and a scrolling
// gradient. Every output is one register stage behind the pixel counters,
// so all outputs stay mutually aligned.
module vga_timing_pattern_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int CHECK_LOG2 = 5,
    parameter int HW         = 10,
    parameter int VW         = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    mode,
    input  logic [11:0]   fg,
    output logic [3:0]    r,
    output logic [3:0]    g,
    output logic [3:0]    b,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int BAR_W   = H_VISIBLE / 8;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] BAR_LAST   = HW'(BAR_W - 1);

    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [7:0]    frame_num;
    logic [1:0]    mode_reg;
    logic [HW-1:0] bar_pix;
    logic [2:0]    bar_k;

    logic          h_wrap;
    logic          v_wrap;
    logic          frame_begin;
    logic          visible;
    logic          hs_act;
    logic          vs_act;
    logic [1:0]    eff_mode;
    logic [7:0]    grad_sum;
    logic          check_odd;
    logic [11:0]   pix;

    assign h_wrap      = (h_cnt == H_LAST);
    assign v_wrap      = (v_cnt == V_LAST);
    assign frame_begin = (h_cnt == '0) && (v_cnt == '0);

    // Pixel and line counters; the frame counter advances as the last pixel of the frame wraps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_num <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            if (v_wrap) begin
                v_cnt     <= '0;
                frame_num <= frame_num + 8'd1;
            end else begin
                v_cnt <= v_cnt + VW'(1);
            end
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Bar sub-counter tracking which eighth of the visible line h_cnt is in, avoiding a divider
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bar_pix <= '0;
            bar_k   <= '0;
        end else if (h_wrap) begin
            bar_pix <= '0;
            bar_k   <= '0;
        end else if (bar_pix == BAR_LAST) begin
            bar_pix <= '0;
            bar_k   <= bar_k + 3'd1;
        end else begin
            bar_pix <= bar_pix + HW'(1);
        end
    end

    // Pattern select is captured once per frame so a mid-frame change waits for the next frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_reg <= '0;
        end else if (frame_begin) begin
            mode_reg <= mode;
        end
    end

    // Region decode and pattern colour for the current counter position
    always_comb begin
        visible   = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        hs_act    = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        vs_act    = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        eff_mode  = frame_begin ? mode : mode_reg;
        grad_sum  = h_cnt[7:0] + frame_num;
        check_odd = h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2];
        pix       = '0;
        case (eff_mode)
            2'd0: pix = fg;
            2'd1: pix = {{4{bar_k[2]}}, {4{bar_k[1]}}, {4{bar_k[0]}}};
            2'd2: pix = check_odd ? 12'h000 : 12'hFFF;
            2'd3: pix = {grad_sum[7:4], v_cnt[7:4], frame_num[7:4]};
            default: pix = '0;
        endcase
    end

    // Output register stage: everything reflects the previous cycle's counter state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r           <= '0;
            g           <= '0;
            b           <= '0;
            hs          <= ~HS_ON;
            vs          <= ~VS_ON;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            hs          <= hs_act ? HS_ON : ~HS_ON;
            vs          <= vs_act ? VS_ON : ~VS_ON;
            de          <= visible;
            line_start  <= (h_cnt == '0);
            frame_start <= frame_begin;
            frame_cnt   <= frame_num;
            if (visible) begin
                {r, g, b} <= pix;
                x         <= h_cnt;
                y         <= v_cnt;
            end else begin
                {r, g, b} <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Testbench for vga_timing_pattern_gen: two scaled-down instances (active-low
// and active-high syncs) are compared every clock against a reference model
// that derives the expected outputs from elapsed time since reset, plus
// directed checks of periods, sync placement, bars, checkerboard, mode
// switching and mid-frame reset.
module tb_vga_timing_pattern_gen;

    typedef struct packed {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
        int cl; int hpol; int vpol;
    } cfg_t;

    typedef struct packed {
        logic [3:0] r; logic [3:0] g; logic [3:0] b;
        logic hs; logic vs; logic de;
        logic [9:0] x; logic [9:0] y;
        logic ls; logic fs;
        logic [7:0] fc;
    } obs_t;

    localparam cfg_t C0 = '{64, 4, 8, 4, 24, 2, 2, 3, 2, 0, 0};
    localparam cfg_t C1 = '{32, 8, 6, 2, 16, 1, 3, 2, 3, 1, 1};
    localparam int HT0 = 80;
    localparam int VT0 = 31;
    localparam int FRAME0 = HT0 * VT0;
    localparam int HT1 = 48;
    localparam int VT1 = 22;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [11:0] fg = 12'h000;

    logic [3:0] r0, g0, b0, r1, g1, b1;
    logic hs0, vs0, de0, ls0, fs0, hs1, vs1, de1, ls1, fs1;
    logic [9:0] x0, y0, x1, y1;
    logic [7:0] fc0, fc1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int md0 = 0, md1 = 0;
    int lx0 = 0, ly0 = 0, lx1 = 0, ly1 = 0;
    string tname = "init";

    vga_timing_pattern_gen #(
        .H_VISIBLE(C0.hv), .H_FRONT(C0.hf), .H_SYNC(C0.hs), .H_BACK(C0.hb),
        .V_VISIBLE(C0.vv), .V_FRONT(C0.vf), .V_SYNC(C0.vs), .V_BACK(C0.vb),
        .HS_POL(C0.hpol), .VS_POL(C0.vpol), .CHECK_LOG2(C0.cl), .HW(10), .VW(10)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .fg(fg),
        .r(r0), .g(g0), .b(b0), .hs(hs0), .vs(vs0), .de(de0), .x(x0), .y(y0),
        .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
    );

    vga_timing_pattern_gen #(
        .H_VISIBLE(C1.hv), .H_FRONT(C1.hf), .H_SYNC(C1.hs), .H_BACK(C1.hb),
        .V_VISIBLE(C1.vv), .V_FRONT(C1.vf), .V_SYNC(C1.vs), .V_BACK(C1.vb),
        .HS_POL(C1.hpol), .VS_POL(C1.vpol), .CHECK_LOG2(C1.cl), .HW(10), .VW(10)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .fg(fg),
        .r(r1), .g(g1), .b(b1), .hs(hs1), .vs(vs1), .de(de1), .x(x1), .y(y1),
        .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
    );

    // Free-running pixel clock
    always #5 clk = ~clk;

    // Safety net against a hung run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic obs_t reset_obs(input cfg_t c);
        obs_t o;
        o = '0;
        o.hs = !c.hpol[0];
        o.vs = !c.vpol[0];
        return o;
    endfunction

    // Expected outputs for the pixel at position p (clocks since the frame-0 origin)
    function automatic obs_t model(input cfg_t c, input int p, input int md,
                                   input logic [11:0] fgv, input int lx, input int ly);
        obs_t o;
        int ht, vt, h, v, f, k;
        logic [2:0] kb;
        ht = c.hv + c.hf + c.hs + c.hb;
        vt = c.vv + c.vf + c.vs + c.vb;
        h = p % ht;
        v = (p / ht) % vt;
        f = p / (ht * vt);
        o = '0;
        o.de = (h < c.hv) && (v < c.vv);
        o.hs = (h >= c.hv + c.hf && h < c.hv + c.hf + c.hs) ? c.hpol[0] : !c.hpol[0];
        o.vs = (v >= c.vv + c.vf && v < c.vv + c.vf + c.vs) ? c.vpol[0] : !c.vpol[0];
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
        o.fc = 8'(f % 256);
        if (o.de) begin
            o.x = 10'(h);
            o.y = 10'(v);
            case (md)
                0: {o.r, o.g, o.b} = fgv;
                1: begin
                    k = h / (c.hv / 8);
                    kb = 3'(k);
                    o.r = {4{kb[2]}};
                    o.g = {4{kb[1]}};
                    o.b = {4{kb[0]}};
                end
                2: if ((((h >> c.cl) ^ (v >> c.cl)) & 1) == 0) {o.r, o.g, o.b} = 12'hFFF;
                default: begin
                    o.r = 4'(((h + f) % 256) / 16);
                    o.g = 4'((v % 256) / 16);
                    o.b = 4'((f % 256) / 16);
                end
            endcase
        end else begin
            o.x = 10'(lx);
            o.y = 10'(ly);
        end
        return o;
    endfunction

    // One clock: advance, then compare both instances against the model
    task automatic step();
        logic was_rst;
        obs_t e0, e1, a0, a1;
        int p;
        was_rst = !rst_n;
        @(posedge clk);
        @(negedge clk);
        if (was_rst) begin
            cyc = 0;
            lx0 = 0; ly0 = 0; lx1 = 0; ly1 = 0;
            e0 = reset_obs(C0);
            e1 = reset_obs(C1);
        end else begin
            cyc++;
            p = cyc - 1;
            if (p % HT0 == 0 && (p / HT0) % VT0 == 0) md0 = int'(mode);
            if (p % HT1 == 0 && (p / HT1) % VT1 == 0) md1 = int'(mode);
            e0 = model(C0, p, md0, fg, lx0, ly0);
            e1 = model(C1, p, md1, fg, lx1, ly1);
            lx0 = int'(e0.x); ly0 = int'(e0.y);
            lx1 = int'(e1.x); ly1 = int'(e1.y);
        end
        a0 = {r0, g0, b0, hs0, vs0, de0, x0, y0, ls0, fs0, fc0};
        a1 = {r1, g1, b1, hs1, vs1, de1, x1, y1, ls1, fs1, fc1};
        total++;
        if (a0 !== e0) begin
            bad++;
            $display("[TB] FAIL %s model_dut0 cycle=%0d: got %h, required %h", tname, cyc, a0, e0);
        end
        total++;
        if (a1 !== e1) begin
            bad++;
            $display("[TB] FAIL %s model_dut1 cycle=%0d: got %h, required %h", tname, cyc, a1, e1);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until dut0/dut1 frame_start pulses; an expired budget is a failure
    task automatic wait_fs(input int which, input int budget, output int used);
        logic seen;
        used = 0;
        seen = 1'b0;
        while (!seen && used < budget) begin
            step();
            used++;
            seen = (which == 0) ? fs0 : fs1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL %s wait_frame_start dut%0d: none within %0d clocks, required a pulse", tname, which, budget);
        end
    endtask

    task automatic test_reset();
        tname = "reset";
        rst_n = 1'b0;
        mode = 2'd3;
        fg = 12'hABC;
        run(3);
        total++;
        if ({r0, g0, b0, de0, ls0, fs0, fc0} !== 23'd0) begin
            bad++;
            $display("[TB] FAIL reset_dut0_zero: got %h, required 0", {r0, g0, b0, de0, ls0, fs0, fc0});
        end
        total++;
        if ({hs0, vs0, hs1, vs1} !== 4'b1100) begin
            bad++;
            $display("[TB] FAIL reset_sync_idle: got %b, required 1100", {hs0, vs0, hs1, vs1});
        end
        total++;
        if ({x0, y0} !== 20'd0) begin
            bad++;
            $display("[TB] FAIL reset_xy: got %h, required 0", {x0, y0});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int used, gap, ls, dn, run_len, max_run;
        tname = "back_to_back";
        mode = 2'd0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_fs(0, 10, used);
        total++;
        if (used != 1 || fc0 !== 8'd0) begin
            bad++;
            $display("[TB] FAIL first_frame_start: got delay=%0d fc=%0d, required delay=1 fc=0", used, fc0);
        end
        for (int f = 1; f <= 2; f++) begin
            gap = 0; ls = 0; dn = 0; run_len = 0; max_run = 0;
            do begin
                step();
                gap++;
                if (ls0) ls++;
                if (de0) begin
                    dn++;
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                end else begin
                    run_len = 0;
                end
            end while (!fs0 && gap < 3 * FRAME0);
            total++;
            if (gap != FRAME0) begin
                bad++;
                $display("[TB] FAIL frame_period: got %0d, required %0d", gap, FRAME0);
            end
            total++;
            if (ls != VT0) begin
                bad++;
                $display("[TB] FAIL line_pulses: got %0d, required %0d", ls, VT0);
            end
            total++;
            if (dn != C0.hv * C0.vv || max_run != C0.hv) begin
                bad++;
                $display("[TB] FAIL de_count: got %0d run %0d, required %0d run %0d", dn, max_run, C0.hv * C0.vv, C0.hv);
            end
            total++;
            if (fc0 !== 8'(f)) begin
                bad++;
                $display("[TB] FAIL frame_cnt: got %0d, required %0d", fc0, f);
            end
        end
    endtask

    task automatic test_sync();
        int used, off, len, cnt;
        tname = "sync";
        wait_fs(0, 2 * FRAME0, used);
        off = 0;
        while (hs0 !== 1'b0 && off < 200) begin step(); off++; end
        total++;
        if (off != C0.hv + C0.hf) begin
            bad++;
            $display("[TB] FAIL hsync_offset: got %0d, required %0d", off, C0.hv + C0.hf);
        end
        len = 1;
        while (len < 200) begin
            step();
            if (hs0 !== 1'b0) break;
            len++;
        end
        total++;
        if (len != C0.hs) begin
            bad++;
            $display("[TB] FAIL hsync_width: got %0d, required %0d", len, C0.hs);
        end
        wait_fs(0, 2 * FRAME0, used);
        off = 0;
        while (vs0 !== 1'b0 && off < 2 * FRAME0) begin step(); off++; end
        total++;
        if (off != (C0.vv + C0.vf) * HT0 || ls0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL vsync_offset: got %0d ls=%b, required %0d ls=1", off, ls0, (C0.vv + C0.vf) * HT0);
        end
        len = 1;
        while (len < 2 * FRAME0) begin
            step();
            if (vs0 !== 1'b0) break;
            len++;
        end
        total++;
        if (len != C0.vs * HT0) begin
            bad++;
            $display("[TB] FAIL vsync_width: got %0d, required %0d", len, C0.vs * HT0);
        end
        wait_fs(1, 4 * FRAME0, used);
        cnt = (hs1 === 1'b1) ? 1 : 0;
        for (int i = 1; i < HT1; i++) begin
            step();
            if (hs1 === 1'b1) cnt++;
        end
        total++;
        if (cnt != C1.hs) begin
            bad++;
            $display("[TB] FAIL hsync_high_pol: got %0d, required %0d", cnt, C1.hs);
        end
    endtask

    task automatic test_bars();
        int used, k;
        logic [2:0] kb;
        logic [11:0] exp_c;
        tname = "bars";
        mode = 2'd1;
        wait_fs(0, 2 * FRAME0, used);
        for (int i = 0; i < HT0; i++) begin
            if (i > 0) step();
            k = i / 8;
            kb = 3'(k);
            exp_c = (i < C0.hv) ? {{4{kb[2]}}, {4{kb[1]}}, {4{kb[0]}}} : 12'h000;
            total++;
            if ({r0, g0, b0} !== exp_c) begin
                bad++;
                $display("[TB] FAIL bar_colour x=%0d: got %h, required %h", i, {r0, g0, b0}, exp_c);
            end
        end
    endtask

    task automatic test_checker();
        int used, cur;
        int offs[5];
        logic [11:0] want[5];
        tname = "checker";
        offs = '{0, 4, 8, 3 * HT0 + 7, 4 * HT0 + 4};
        want = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF};
        mode = 2'd2;
        wait_fs(0, 2 * FRAME0, used);
        cur = 0;
        for (int i = 0; i < 5; i++) begin
            run(offs[i] - cur);
            cur = offs[i];
            total++;
            if ({r0, g0, b0} !== want[i]) begin
                bad++;
                $display("[TB] FAIL checker_point %0d: got %h, required %h", i, {r0, g0, b0}, want[i]);
            end
        end
    endtask

    task automatic test_mode_switch();
        int used;
        logic [11:0] fgv;
        tname = "mode_switch";
        fgv = 12'($urandom_range(1, 12'hFFE));
        fg = fgv;
        mode = 2'd0;
        wait_fs(0, 2 * FRAME0, used);
        run(10 * HT0);
        mode = 2'd2;
        run(2 * HT0 + 5);
        total++;
        if ({r0, g0, b0} !== fgv) begin
            bad++;
            $display("[TB] FAIL mid_frame_keeps_fg: got %h, required %h", {r0, g0, b0}, fgv);
        end
        wait_fs(0, 2 * FRAME0, used);
        total++;
        if ({r0, g0, b0} !== 12'hFFF) begin
            bad++;
            $display("[TB] FAIL next_frame_checker00: got %h, required fff", {r0, g0, b0});
        end
        run(4);
        total++;
        if ({r0, g0, b0} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL next_frame_checker40: got %h, required 000", {r0, g0, b0});
        end
    endtask

    task automatic test_midframe_reset();
        int used;
        tname = "midframe_reset";
        mode = 2'd3;
        wait_fs(0, 2 * FRAME0, used);
        run($urandom_range(100, 2000));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++;
        if ({r0, g0, b0, de0, ls0, fs0, fc0, x0, y0} !== 43'd0 || {hs0, vs0, hs1, vs1} !== 4'b1100) begin
            bad++;
            $display("[TB] FAIL reset_values: got %h %b, required 0 1100",
                     {r0, g0, b0, de0, ls0, fs0, fc0, x0, y0}, {hs0, vs0, hs1, vs1});
        end
        wait_fs(0, 10, used);
        total++;
        if (used != 1 || fc0 !== 8'd0) begin
            bad++;
            $display("[TB] FAIL restart_frame: got delay=%0d fc=%0d, required delay=1 fc=0", used, fc0);
        end
        wait_fs(0, 2 * FRAME0, used);
        total++;
        if (used + 1 != FRAME0 + 1 || fc0 !== 8'd1) begin
            bad++;
            $display("[TB] FAIL next_frame_after_reset: got %0d fc=%0d, required %0d fc=1", used + 1, fc0, FRAME0 + 1);
        end
    endtask

    task automatic test_random();
        tname = "random";
        for (int s = 0; s < 14; s++) begin
            mode = 2'($urandom_range(0, 3));
            fg = 12'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            run($urandom_range(50, 1500));
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_sync();
        test_bars();
        test_checker();
        test_mode_switch();
        test_midframe_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
